seq_gen: RTL and testbench

Serial pattern generator: the transmit-side counterpart of the team's serial sequence detector. Accepts a PAT_W-bit pattern plus repeat count and inter-frame gap through a valid/ready start handshake, then drives the pattern MSB-first, one bit per clock, on `dout`, qualified by `dout_en`. Used as a stimulus/link source feeding serial detectors and checkers in the typical-circuit set.

---
 rtl/seq_gen.sv | 163 ++++++++++++++++
 tb/tb_seq_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Accepts a PAT_W-bit pattern, repeat count and inter-frame gap through a
// valid/ready start handshake, then shifts the pattern out MSB-first, one bit
// per clock, on dout qualified by dout_en. All outputs except start_ready are
// registered; the next-cycle output values are derived from the next state so
// that the first pattern bit appears in the cycle right after the accept edge.

module seq_gen #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_num,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_en,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r,  state_nx;
  logic [PAT_W-1:0]   shadow_r, shadow_nx;
  logic [IDX_W-1:0]   idx_r,    idx_nx;
  logic [CNT_W-1:0]   rem_r,    rem_nx;
  logic [GAP_W-1:0]   gap_r,    gap_nx;
  logic [GAP_W-1:0]   gcnt_r,   gcnt_nx;
  logic               load_s;
  logic               dout_nx;
  logic               dout_en_nx;
  logic               frame_start_nx;
  logic               busy_nx;
  logic               done_nx;

  // Handshake readiness is decoded straight from the state register.
  assign start_ready = (state_r == IDLE) || (state_r == DONE);

  // Next-state, next-counter and next-output computation.
  always_comb begin
    state_nx  = state_r;
    shadow_nx = shadow_r;
    idx_nx    = idx_r;
    rem_nx    = rem_r;
    gap_nx    = gap_r;
    gcnt_nx   = gcnt_r;
    load_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // abort is a no-op in IDLE, so a concurrent start is still taken
        if (start_valid) begin
          load_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      SEND: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (idx_r == {IDX_W{1'b0}}) begin
          if (rem_r > CNT_W'(1)) begin
            rem_nx = rem_r - CNT_W'(1);
            if (gap_r != {GAP_W{1'b0}}) begin
              state_nx = GAP;
              gcnt_nx  = gap_r;
            end else begin
              idx_nx = IDX_TOP;
            end
          end else begin
            state_nx = DONE;
          end
        end else begin
          idx_nx = idx_r - IDX_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (gcnt_r == GAP_W'(1)) begin
          state_nx = SEND;
          idx_nx   = IDX_TOP;
        end else begin
          gcnt_nx = gcnt_r - GAP_W'(1);
        end
      end
      DONE: begin
        // abort outranks a start arriving in the done slot
        if (abort) begin
          state_nx = IDLE;
        end else if (start_valid) begin
          load_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (load_s) begin
      state_nx  = SEND;
      shadow_nx = pattern;
      idx_nx    = IDX_TOP;
      rem_nx    = (repeat_num == {CNT_W{1'b0}}) ? CNT_W'(1) : repeat_num;
      gap_nx    = gap;
    end else begin
      shadow_nx = shadow_nx;
    end

    dout_en_nx     = (state_nx == SEND);
    dout_nx        = dout_en_nx ? shadow_nx[idx_nx] : 1'b0;
    frame_start_nx = dout_en_nx && (idx_nx == IDX_TOP);
    busy_nx        = (state_nx == SEND) || (state_nx == GAP);
    done_nx        = (state_nx == DONE);
  end

  // State, counters and registered outputs; rst returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shadow_r    <= {PAT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      rem_r       <= {CNT_W{1'b0}};
      gap_r       <= {GAP_W{1'b0}};
      gcnt_r      <= {GAP_W{1'b0}};
      dout        <= 1'b0;
      dout_en     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_nx;
      shadow_r    <= shadow_nx;
      idx_r       <= idx_nx;
      rem_r       <= rem_nx;
      gap_r       <= gap_nx;
      gcnt_r      <= gcnt_nx;
      dout        <= dout_nx;
      dout_en     <= dout_en_nx;
      frame_start <= frame_start_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen.
// Expected waveforms are computed arithmetically from pattern, repeat count
// and gap: cycle k of a transfer falls in instance slot k % (PAT_W + gap),
// carrying a pattern bit when the slot offset is below PAT_W.

module tb_seq_gen;

  localparam int P = 5;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [P-1:0] pattern;
  logic [7:0]   repeat_num;
  logic [3:0]   gap;
  logic         abort;
  logic         dout;
  logic         dout_en;
  logic         frame_start;
  logic         busy;
  logic         done;

  int n_assert;
  int n_fail;

  seq_gen #(.PAT_W(P), .CNT_W(8), .GAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern     (pattern),
    .repeat_num  (repeat_num),
    .gap         (gap),
    .abort       (abort),
    .dout        (dout),
    .dout_en     (dout_en),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs of a quiet generator (idle, after abort or after reset).
  task automatic check_quiet(input string tag);
    check({tag, ".dout_en"}, 32'(dout_en), 32'd0);
    check({tag, ".dout"}, 32'(dout), 32'd0);
    check({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".start_ready"}, 32'(start_ready), 32'd1);
  endtask

  // Outputs of cycle k of an active transfer.
  task automatic check_cycle(input logic [P-1:0] pat, input int g, input int k);
    int  w;
    logic e_en, e_d, e_fs;
    w    = k % (P + g);
    e_en = (w < P);
    e_d  = e_en ? pat[P-1-w] : 1'b0;
    e_fs = (w == 0);
    check($sformatf("dout_en[k=%0d]", k), 32'(dout_en), 32'(e_en));
    check($sformatf("dout[k=%0d]", k), 32'(dout), 32'(e_d));
    check($sformatf("frame_start[k=%0d]", k), 32'(frame_start), 32'(e_fs));
    check($sformatf("busy[k=%0d]", k), 32'(busy), 32'd1);
    check($sformatf("start_ready[k=%0d]", k), 32'(start_ready), 32'd0);
    check($sformatf("done[k=%0d]", k), 32'(done), 32'd0);
  endtask

  // Called just after the accept edge; ends just after the done edge.
  task automatic check_frame(input logic [P-1:0] pat, input int rep, input int g);
    int r, len;
    r   = (rep == 0) ? 1 : rep;
    len = r * P + (r - 1) * g;
    for (int k = 0; k < len; k++) begin
      check_cycle(pat, g, k);
      step();
    end
    check("done.pulse", 32'(done), 32'd1);
    check("done.dout_en", 32'(dout_en), 32'd0);
    check("done.dout", 32'(dout), 32'd0);
    check("done.busy", 32'(busy), 32'd0);
    check("done.start_ready", 32'(start_ready), 32'd1);
  endtask

  task automatic run_xfer(input logic [P-1:0] pat, input int rep, input int g);
    pattern     = pat;
    repeat_num  = 8'(rep);
    gap         = 4'(g);
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    pattern     = P'($urandom);
    repeat_num  = 8'($urandom);
    gap         = 4'($urandom);
    check_frame(pat, rep, g);
    step();
    check_quiet("after_done");
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    pattern     = 5'b00000;
    repeat_num  = 8'd0;
    gap         = 4'd0;
    abort       = 1'b0;
    step();
    step();
    check_quiet("reset");
    rst = 1'b0;
    step();
    check_quiet("idle");

    // single instance, three back-to-back, two with a gap
    run_xfer(5'b10110, 1, 0);
    run_xfer(5'b10110, 3, 0);
    run_xfer(5'b10110, 2, 3);

    // start held through the transfer: ignored while busy, taken in DONE
    pattern     = 5'b10110;
    repeat_num  = 8'd1;
    gap         = 4'd0;
    start_valid = 1'b1;
    step();
    pattern = 5'b01001;
    check_frame(5'b10110, 1, 0);
    step();
    start_valid = 1'b0;
    check_frame(5'b01001, 1, 0);
    step();
    check_quiet("b2b_end");

    // abort while bit index 2 is on dout
    pattern     = 5'b10110;
    repeat_num  = 8'd2;
    gap         = 4'd0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_cycle(5'b10110, 0, k);
      if (k < 2) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("abort");
    step();
    check_quiet("abort_no_done");

    // reset in the middle of a gap
    pattern     = 5'b11011;
    repeat_num  = 8'd2;
    gap         = 4'd3;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check_cycle(5'b11011, 3, k);
      if (k < 6) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("rst_mid_gap");

    // abort in IDLE is a no-op; concurrent start is accepted
    pattern     = 5'b11100;
    repeat_num  = 8'd1;
    gap         = 4'd0;
    start_valid = 1'b1;
    abort       = 1'b1;
    step();
    start_valid = 1'b0;
    abort       = 1'b0;
    check_frame(5'b11100, 1, 0);
    // abort beats a start in the DONE slot
    start_valid = 1'b1;
    abort       = 1'b1;
    step();
    start_valid = 1'b0;
    abort       = 1'b0;
    check_quiet("abort_in_done");

    // repeat 0 behaves as 1; maximal gap
    run_xfer(5'b10110, 0, 0);
    run_xfer(5'b10110, 2, 15);

    // randomized transfers
    for (int t = 0; t < 20; t++) begin
      logic [P-1:0] rp;
      int rr, rg;
      rp = P'($urandom);
      rr = int'($urandom_range(0, 4));
      rg = int'($urandom_range(0, 4));
      run_xfer(rp, rr, rg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
